// File: rtl/ctest_switch_debounce.sv
// Switch conditioning: 2-flop synchroniser plus per-bit stability counter, giving clean levels and change strobes.
// Optional sticky edge flags with irq are enabled by defining CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN.
module ctest_switch_debounce #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches_out,
    output logic [WIDTH-1:0] change_pulse,
    output logic             any_change
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_latched,
    output logic             irq
`endif
);

    localparam int unsigned      CNT_W = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES == 0) begin : g_param_check
        $error("ctest_switch_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0]            out_next;
    logic [WIDTH-1:0]            accept;

    // Counter saturates at TERM: reaching it with the level still different is the accept.
    always_comb begin
        cnt_next = '0;
        out_next = switches_out;
        accept   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] == switches_out[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == TERM) begin
                accept[i]   = 1'b1;
                out_next[i] = sync2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= RESET_VALUE;
            sync2        <= RESET_VALUE;
            switches_out <= RESET_VALUE;
            cnt          <= '0;
            change_pulse <= '0;
            any_change   <= 1'b0;
        end else begin
            sync1        <= switches_raw;
            sync2        <= sync1;
            switches_out <= out_next;
            cnt          <= cnt_next;
            change_pulse <= accept;
            any_change   <= |accept;
        end
    end

`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
    logic [WIDTH-1:0] latched_next;

    // Set takes priority over a coincident clear so no accepted edge is lost.
    always_comb begin
        latched_next = (edge_latched & ~edge_clear) | accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_latched <= '0;
            irq          <= 1'b0;
        end else begin
            edge_latched <= latched_next;
            irq          <= |latched_next;
        end
    end
`endif

endmodule

// File: tb/tb_ctest_switch_debounce.sv
// Self-checking bench for ctest_switch_debounce (DEBOUNCE_CYCLES=4): segment table plus per-cycle scoreboard.
// Define CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN to also check the edge latch outputs.
module tb_ctest_switch_debounce;

    localparam int DC = 4;

    logic       clk;
    logic       reset;
    logic [7:0] switches_raw;
    logic [7:0] switches_out;
    logic [7:0] change_pulse;
    logic       any_change;
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
    logic [7:0] edge_clear;
    logic [7:0] edge_latched;
    logic       irq;
`endif

    ctest_switch_debounce #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(DC),
        .RESET_VALUE    (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .switches_raw(switches_raw),
        .switches_out(switches_out),
        .change_pulse(change_pulse),
        .any_change  (any_change)
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
        ,
        .edge_clear  (edge_clear),
        .edge_latched(edge_latched),
        .irq         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic [7:0] pulse;
        logic       any;
        logic [7:0] latched;
        logic       irq;
    } exp_t;

    typedef struct {
        logic [7:0]  raw;
        int unsigned cycles;
        logic [7:0]  exp_out;
        logic [7:0]  exp_por;
        int unsigned exp_np;
    } seg_t;

    exp_t sb[$];
    seg_t segs[$];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference model: accept a bit when its last DC synced samples all differ from the output.
    logic [7:0] m_sync1, m_sync2, m_out, m_latched;
    logic [7:0] hist[$];
    logic [7:0] seg_por;
    int unsigned seg_np;
    logic       seen_set;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1   = 8'h00;
        m_sync2   = 8'h00;
        m_out     = 8'h00;
        m_latched = 8'h00;
        hist.delete();
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            cmp("switches_out", {24'd0, switches_out}, {24'd0, e.out});
            cmp("change_pulse", {24'd0, change_pulse}, {24'd0, e.pulse});
            cmp("any_change", {31'd0, any_change}, {31'd0, e.any});
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
            cmp("edge_latched", {24'd0, edge_latched}, {24'd0, e.latched});
            cmp("irq", {31'd0, irq}, {31'd0, e.irq});
            if (edge_latched[0] && change_pulse[0]) seen_set = 1'b1;
`endif
        end
        seg_por |= change_pulse;
        if (any_change) seg_np++;
    endtask

    task automatic step(input logic [7:0] raw, input logic [7:0] clr);
        logic [7:0] acc;
        exp_t       e;
        switches_raw = raw;
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
        edge_clear = clr;
`endif
        hist.push_back(m_sync2);
        if (hist.size() > DC) void'(hist.pop_front());
        acc = 8'h00;
        if (hist.size() == DC) begin
            for (int b = 0; b < 8; b++) begin
                acc[b] = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_out[b]) acc[b] = 1'b0;
            end
        end
        m_out     = m_out ^ acc;
        m_latched = (m_latched & ~clr) | acc;
        e = '{out: m_out, pulse: acc, any: |acc, latched: m_latched, irq: |m_latched};
        m_sync2 = m_sync1;
        m_sync1 = raw;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        switches_raw = 8'h00;
`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
        edge_clear   = 8'h00;
`endif
        model_reset();
        seg_por  = 8'h00;
        seg_np   = 0;
        seen_set = 1'b0;
        #2;
        cmp("reset_out", {24'd0, switches_out}, 32'h00);
        cmp("reset_pulse", {24'd0, change_pulse}, 32'h00);
        cmp("reset_any", {31'd0, any_change}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        segs.push_back('{8'h00, 50, 8'h00, 8'h00, 0});
        segs.push_back('{8'h01, 10, 8'h01, 8'h01, 1});
        segs.push_back('{8'h00, 10, 8'h00, 8'h01, 1});
        segs.push_back('{8'h08,  3, 8'h00, 8'h00, 0});
        segs.push_back('{8'h00, 10, 8'h00, 8'h00, 0});
        segs.push_back('{8'h04,  2, 8'h00, 8'h00, 0});
        segs.push_back('{8'h00,  1, 8'h00, 8'h00, 0});
        segs.push_back('{8'h04,  2, 8'h00, 8'h00, 0});
        segs.push_back('{8'h04,  8, 8'h04, 8'h04, 1});
        segs.push_back('{8'h00, 10, 8'h00, 8'h04, 1});
        segs.push_back('{8'hA5, 10, 8'hA5, 8'hA5, 1});
        segs.push_back('{8'h00, 10, 8'h00, 8'hA5, 1});

        for (int s = 0; s < segs.size(); s++) begin
            seg_por = 8'h00;
            seg_np  = 0;
            for (int unsigned c = 0; c < segs[s].cycles; c++) step(segs[s].raw, 8'h00);
            cmp($sformatf("seg%0d_out", s), {24'd0, switches_out}, {24'd0, segs[s].exp_out});
            cmp($sformatf("seg%0d_pulses", s), {24'd0, seg_por}, {24'd0, segs[s].exp_por});
            cmp($sformatf("seg%0d_npulse", s), seg_np, segs[s].exp_np);
        end

        // Bit 1 toggling every cycle never accumulates enough stable cycles.
        seg_por = 8'h00;
        seg_np  = 0;
        for (int t = 0; t < 30; t++) step((t % 2 == 0) ? 8'h02 : 8'h00, 8'h00);
        cmp("toggle_out", {24'd0, switches_out}, 32'h00);
        cmp("toggle_npulse", seg_np, 32'd0);

        // Reset mid-count: output drops asynchronously, then full latency after release.
        for (int t = 0; t < 10; t++) step(8'h5A, 8'h00);
        cmp("pre_reset_out", {24'd0, switches_out}, 32'h5A);
        step(8'hFF, 8'h00);
        step(8'hFF, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset_out", {24'd0, switches_out}, 32'h00);
        cmp("async_reset_any", {31'd0, any_change}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cmp("held_reset_out", {24'd0, switches_out}, 32'h00);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(8'hFF, 8'h00);
            if (k < 6) cmp($sformatf("post_reset_hold%0d", k), {24'd0, switches_out}, 32'h00);
        end
        cmp("post_reset_accept_out", {24'd0, switches_out}, 32'hFF);
        cmp("post_reset_accept_pulse", {24'd0, change_pulse}, 32'hFF);
        step(8'hFF, 8'h00);
        cmp("post_reset_pulse_cleared", {24'd0, change_pulse}, 32'h00);

`ifdef CTEST_SWITCH_DEBOUNCE_EDGE_LATCH_EN
        step(8'hFF, 8'hFF);
        cmp("latch_cleared_all", {24'd0, edge_latched}, 32'h00);
        for (int t = 0; t < 8; t++) step(8'hFE, 8'h00);
        cmp("latch_set", {24'd0, edge_latched}, 32'h01);
        cmp("latch_irq_set", {31'd0, irq}, 32'h1);
        step(8'hFE, 8'h01);
        cmp("latch_clear", {24'd0, edge_latched}, 32'h00);
        cmp("latch_irq_clear", {31'd0, irq}, 32'h0);
        seen_set = 1'b0;
        for (int t = 0; t < 8; t++) step(8'hFF, 8'h01);
        cmp("latch_set_wins", {31'd0, seen_set}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
